comparison_tree_pipe: RTL

//  Pipelined, parametrised argmin selector for the A* open-list front end.

---
 rtl/comparison_tree_pipe_if.sv | 27 ++
 rtl/comparison_tree_pipe.sv | 89 ++++++++
 2 files changed

// File: rtl/comparison_tree_pipe_if.sv
// Candidate bus and handshake for the argmin tree.
// The master drives beats in; the slave returns the winning candidate.
interface comparison_tree_pipe_if #(
  parameter int N_NODES = 16,
  parameter int F_W     = 16,
  parameter int D_W     = 32
);
  localparam int IDX_W = $clog2(N_NODES);

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_NODES-1:0]     node_vld;
  logic [N_NODES*F_W-1:0] node_f;
  logic [N_NODES*D_W-1:0] node_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   min_any;
  logic [IDX_W-1:0]       min_idx;
  logic [F_W-1:0]         min_f;
  logic [D_W-1:0]         min_data;

  modport master (output flush, in_valid, node_vld, node_f, node_data, out_ready,
                  input  in_ready, out_valid, min_any, min_idx, min_f, min_data);
  modport slave  (input  flush, in_valid, node_vld, node_f, node_data, out_ready,
                  output in_ready, out_valid, min_any, min_idx, min_f, min_data);
endinterface

// File: rtl/comparison_tree_pipe.sv
// Pipelined argmin over N_NODES candidates: one registered 2:1 compare level per tree depth,
// laid out as a heap (node j has children 2j and 2j+1; leaves are the live input candidates).
module comparison_tree_pipe #(
  parameter int N_NODES = 16,
  parameter int F_W     = 16,
  parameter int D_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  comparison_tree_pipe_if.slave bus
);
  localparam int IDX_W  = $clog2(N_NODES);
  localparam int STAGES = IDX_W;
  localparam int NODES  = 2 * N_NODES;

  typedef struct packed {
    logic             v;
    logic [F_W-1:0]   f;
    logic [IDX_W-1:0] i;
    logic [D_W-1:0]   d;
  } cand_t;

  // a is always the lower-index side, so a strict compare keeps ties on the lower index.
  function automatic cand_t pick(input cand_t a, input cand_t b);
    cand_t w;
    w   = (b.v && (!a.v || (b.f < a.f))) ? b : a;
    w.v = a.v | b.v;
    return w;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic              advance;
  logic              out_valid;
  logic              any_win;
  cand_t             node_q [N_NODES];
  cand_t             node_d [N_NODES];
  cand_t             tree   [NODES];

  assign out_valid    = vld_q[STAGES-1];
  assign advance      = !out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    vld_d = vld_q;
    if (bus.flush)
      vld_d = '0;
    else if (advance)
      vld_d = (vld_q << 1) | STAGES'(bus.in_valid);
  end

  always_comb begin
    for (int k = 0; k < N_NODES; k++)
      tree[k] = node_q[k];
    for (int k = 0; k < N_NODES; k++) begin
      tree[N_NODES+k].v = bus.node_vld[k];
      tree[N_NODES+k].f = bus.node_f[k*F_W +: F_W];
      tree[N_NODES+k].i = IDX_W'(k);
      tree[N_NODES+k].d = bus.node_data[k*D_W +: D_W];
    end
  end

  always_comb begin
    node_d[0] = '0;
    for (int j = 1; j < N_NODES; j++)
      node_d[j] = pick(tree[2*j], tree[2*j+1]);
  end

  // Stage boundary: beat-valid shift register, one bit per tree level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vld_q <= '0;
    else
      vld_q <= vld_d;
  end

  // Stage boundary: every tree level moves up one depth together on advance.
  always_ff @(posedge clk) begin
    if (advance)
      node_q <= node_d;
  end

  // Zeroed unless a valid winner is being presented, which also covers reset and empty beats.
  assign any_win       = out_valid & node_q[1].v;
  assign bus.out_valid = out_valid;
  assign bus.min_any   = any_win;
  assign bus.min_idx   = any_win ? node_q[1].i : '0;
  assign bus.min_f     = any_win ? node_q[1].f : '0;
  assign bus.min_data  = any_win ? node_q[1].d : '0;
endmodule
